// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register: operation encoding used by RTL and bench.
package universal_register_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    LOAD    = 3'd1,
    INC     = 3'd2,
    DEC     = 3'd3,
    SHL     = 3'd4,
    SHR     = 3'd5,
    SAVE    = 3'd6,
    RESTORE = 3'd7
  } op_e;

endpackage

// File: rtl/universal_register.sv
// Universal register: load/inc/dec/shift with a carry flag and a one-deep shadow save/restore slot.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] shadow_r;
  logic             carry_r;

  logic [WIDTH-1:0] out_nxt_s;
  logic [WIDTH-1:0] shadow_nxt_s;
  logic             carry_nxt_s;
  op_e              op_s;

  assign op_s = op_e'(op);

  // Next-state selection; every path starts from hold so unlisted fields keep their value.
  always_comb begin
    out_nxt_s    = out_r;
    carry_nxt_s  = carry_r;
    shadow_nxt_s = shadow_r;
    if (enable) begin
      case (op_s)
        HOLD: begin
          out_nxt_s = out_r;
        end
        LOAD: begin
          out_nxt_s   = in;
          carry_nxt_s = 1'b0;
        end
        INC: begin
          out_nxt_s   = out_r + {{(WIDTH-1){1'b0}}, 1'b1};
          carry_nxt_s = &out_r;
        end
        DEC: begin
          out_nxt_s   = out_r - {{(WIDTH-1){1'b0}}, 1'b1};
          carry_nxt_s = ~|out_r;
        end
        SHL: begin
          out_nxt_s   = {out_r[WIDTH-2:0], serial_in};
          carry_nxt_s = out_r[WIDTH-1];
        end
        SHR: begin
          out_nxt_s   = {serial_in, out_r[WIDTH-1:1]};
          carry_nxt_s = out_r[0];
        end
        SAVE: begin
          shadow_nxt_s = out_r;
        end
        RESTORE: begin
          out_nxt_s   = shadow_r;
          carry_nxt_s = 1'b0;
        end
        default: begin
          out_nxt_s = out_r;
        end
      endcase
    end else begin
      out_nxt_s = out_r;
    end
  end

  // State registers; reset wins over any op presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r    <= RESET_VALUE;
      shadow_r <= RESET_VALUE;
      carry_r  <= 1'b0;
    end else begin
      out_r    <= out_nxt_s;
      shadow_r <= shadow_nxt_s;
      carry_r  <= carry_nxt_s;
    end
  end

  assign out   = out_r;
  assign carry = carry_r;
  assign zero  = ~|out_r;

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits (minimum 2).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the WIDTH-bit value loaded into out and shadow by reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  operation qualifier; 0 means hold.
REQ-006 The block SHALL have port op  input  3  operation select (op_e).
REQ-007 The block SHALL have port in  input  WIDTH  parallel load data.
REQ-008 The block SHALL have port serial_in  input  1  bit shifted in by SHL/SHR.
REQ-009 The block SHALL have port out  output  WIDTH  registered value.
REQ-010 The block SHALL have port carry  output  1  registered carry/borrow/shift-out flag.
REQ-011 The block SHALL have port zero  output  1  combinational flag, 1 when out is all zeros.

Function
REQ-012 With enable=0, out, carry and shadow SHALL hold, regardless of op, in and serial_in.
REQ-013 With enable=1, the selected op SHALL take effect at the next rising edge of clk (latency 1 cycle; result visible on out after that edge).
REQ-014 HOLD (0) SHALL leave out, carry and shadow unchanged.
REQ-015 LOAD (1) SHALL set out to in and clear carry.
REQ-016 INC (2) SHALL set out to out+1 modulo 2^WIDTH; carry = 1 only when the prior out was all ones (wrap to 0).
REQ-017 DEC (3) SHALL set out to out-1 modulo 2^WIDTH; carry = 1 only when the prior out was 0 (borrow, wrap to all ones).
REQ-018 SHL (4) SHALL set out to {out[WIDTH-2:0], serial_in}; carry = prior out[WIDTH-1].
REQ-019 SHR (5) SHALL set out to {serial_in, out[WIDTH-1:1]}; carry = prior out[0].
REQ-020 SAVE (6) SHALL copy the current out into an internal WIDTH-bit shadow register; out and carry unchanged.
REQ-021 RESTORE (7) SHALL set out to shadow and clear carry; shadow unchanged.
REQ-022 SAVE followed by RESTORE on consecutive enabled cycles SHALL return the value saved in the first cycle.
REQ-023 zero SHALL be derived from out only, with no added cycle of latency.
REQ-024 All arithmetic SHALL be WIDTH bits; no output SHALL exceed WIDTH bits.

Reset
REQ-025 On a rising clk edge with reset=1, out SHALL become RESET_VALUE, shadow SHALL become RESET_VALUE, and carry SHALL become 0.
REQ-026 reset SHALL take priority over enable and op on the same edge; the op presented is discarded.
REQ-027 Reset asserted mid-sequence (e.g. between SAVE and RESTORE) SHALL discard the saved value; a later RESTORE SHALL yield RESET_VALUE.
REQ-028 Before the first clk edge with reset=1, outputs SHALL be considered undefined; no asynchronous reset path SHALL exist.

Structure
REQ-029 The enum op_e (HOLD, LOAD, INC, DEC, SHL, SHR, SAVE, RESTORE; 3 bits) SHALL live in shared package universal_register_pkg, imported by the RTL and the bench.
REQ-030 The next-state and next-carry logic SHALL be a single combinational process feeding one sequential process; no sub-module is required.
REQ-031 The block SHALL be a drop-in superset of the existing register: op=LOAD and WIDTH=8 reproduce plain load/enable/reset behaviour.

Verification
REQ-032 The bench SHALL cover: reset=1 one edge, then LOAD in=0x0F enable=1 -> out=0x0F, carry=0, zero=0; then enable=0 with in=0x05 -> out stays 0x0F.
REQ-033 The bench SHALL cover: LOAD 0xFE, INC, INC -> out 0xFF carry 0, then out 0x00 carry 1 zero 1; then DEC -> out 0xFF carry 1.
REQ-034 The bench SHALL cover: LOAD 0x81, SHL serial_in=0 -> out 0x02 carry 1; SHR serial_in=1 -> out 0x81 carry 0.
REQ-035 The bench SHALL cover: LOAD 0x3C, SAVE, LOAD 0x00 (zero=1), RESTORE -> out 0x3C, carry 0.
REQ-036 The bench SHALL cover: LOAD 0x3C, SAVE, reset with enable=1 op=INC on the same edge -> out=RESET_VALUE, carry 0; then RESTORE -> out=RESET_VALUE.
REQ-037 The bench SHALL cover: WIDTH=4 instance, LOAD 0xF, INC -> out 0x0, carry 1; the bench SHALL terminate with a timeout guard.
